// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a little-endian byte stream into 32-bit words,
// writes them at sequential addresses and releases the CPU once the load completes.
module imem_loader #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [15:0]           word_count,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_written
);

   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

   state_t                  state_reg;
   logic [1:0]              lane_reg;
   logic [15:0]             count_reg;
   logic [15:0]             written_reg;
   logic [31:0]             word_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic                    start_ok;

   assign start_ok = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         lane_reg    <= 2'd0;
         count_reg   <= 16'd0;
         written_reg <= 16'd0;
         word_reg    <= 32'd0;
         addr_reg    <= BASE_ADDR;
      end else begin
         case (state_reg)
            RECV: begin
               if (byte_valid) begin
                  word_reg[lane_reg*8 +: 8] <= byte_in;
                  lane_reg                  <= lane_reg + 2'd1;
                  if (lane_reg == 2'd3)
                     state_reg <= WRITE;
               end
            end
            WRITE: begin
               written_reg <= written_reg + 16'd1;
               addr_reg    <= addr_reg + ADDR_WIDTH'(4);
               lane_reg    <= 2'd0;
               state_reg   <= (written_reg + 16'd1 == count_reg) ? DONE : RECV;
            end
            default: begin
               if (start_ok) begin
                  count_reg   <= word_count;
                  written_reg <= 16'd0;
                  addr_reg    <= BASE_ADDR;
                  lane_reg    <= 2'd0;
                  word_reg    <= 32'd0;
                  if (word_count == 16'd0)
                     state_reg <= DONE;
                  else if (int'(word_count) > DEPTH_WORDS)
                     state_reg <= ERR;
                  else
                     state_reg <= RECV;
               end
            end
         endcase
      end
   end

   // Control outputs are pure decodes of the registered state.
   assign byte_ready    = (state_reg == RECV);
   assign mem_we        = (state_reg == WRITE);
   assign busy          = (state_reg == RECV) || (state_reg == WRITE);
   assign done          = (state_reg == DONE);
   assign error         = (state_reg == ERR);
   assign cpu_hold      = (state_reg != DONE);
   assign mem_addr      = addr_reg;
   assign mem_wdata     = word_reg;
   assign words_written = written_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a write-list model built from the byte stream
// is checked against every mem_we pulse, plus literal spot checks per scenario.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] word_count = 16'd0;
   logic [7:0]  byte_in = 8'd0;
   logic        byte_valid = 1'b0;
   logic        byte_ready, mem_we, cpu_hold, busy, done, error;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] words_written;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   imem_loader #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .words_written(words_written)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: every 4 stream bytes form one little-endian word at BASE + 4*index.
   task automatic expect_words(input logic [7:0] bs[$]);
      for (int w = 0; w < bs.size() / 4; w++) begin
         exp_addr_q.push_back(32'(4 * w));
         exp_data_q.push_back({bs[4*w+3], bs[4*w+2], bs[4*w+1], bs[4*w]});
      end
   endtask

   // Compare process: each write pulse must match the next modelled word.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
         if (exp_addr_q.size() == 0) begin
            chk("unexpected_mem_we", 32'd1, 32'd0);
         end else begin
            chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            chk("mem_wdata", mem_wdata, exp_data_q.pop_front());
         end
      end
      chk("cpu_hold_vs_done", {31'd0, cpu_hold}, {31'd0, ~done});
      if (byte_ready === 1'b1) chk("ready_implies_busy", {31'd0, busy}, 32'd1);
   end

   task automatic do_start(input logic [15:0] cnt);
      @(negedge clk);
      start = 1'b1;
      word_count = cnt;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives bytes from a negedge; an accepted byte is one offered while byte_ready is high.
   task automatic send_stream(input logic [7:0] bs[$], input bit gap);
      int i = 0;
      int guard = 0;
      while (i < bs.size() && guard < 200) begin
         if (gap && guard % 2 == 1) begin
            byte_valid = 1'b0;
         end else begin
            byte_valid = 1'b1;
            byte_in = bs[i];
         end
         if (byte_valid && byte_ready) i++;
         guard++;
         @(negedge clk);
      end
      byte_valid = 1'b0;
      if (i != bs.size()) chk("stream_timeout", 32'(i), 32'(bs.size()));
   endtask

   task automatic wait_done();
      int k = 0;
      while (done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("done_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
      chk({tag, "_words_written"}, {16'd0, words_written}, 32'd0);
      chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
   endtask

   initial begin
      logic [7:0] prog2[$];
      logic [7:0] prog1[$];
      logic [7:0] head[$];
      logic [7:0] tail[$];
      bit ready_seen;
      prog2 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h02, 8'hA5, 8'h00};
      prog1 = '{8'h6F, 8'h00, 8'h00, 8'h00};
      head  = '{8'h13, 8'h05};
      tail  = '{8'h00, 8'h00, 8'hB3, 8'h02, 8'hA5, 8'h00};

      // 1: reset
      repeat (3) @(negedge clk);
      check_idle_outputs("rst_held");
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("rst_released");

      // 2: two-word load, continuous stream, DONE exactly 11 cycles after start
      expect_words(prog2);
      do_start(16'd2);
      send_stream(prog2, 1'b0);
      wait_done();
      chk("t2_done_cycle", 32'(cyc - start_cyc), 32'd11);
      chk("t2_words_written", {16'd0, words_written}, 32'd2);
      chk("t2_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("t2_mem_addr_after", mem_addr, 32'h8);
      chk("t2_write_count", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("t2_lit_data0", log_data[0], 32'h00000513);
         chk("t2_lit_data1", log_data[1], 32'h00A502B3);
         chk("t2_lit_addr1", log_addr[1], 32'h4);
      end
      log_addr.delete(); log_data.delete();

      // 3: gapped stream
      expect_words(prog2);
      do_start(16'd2);
      send_stream(prog2, 1'b1);
      wait_done();
      chk("t3_words_written", {16'd0, words_written}, 32'd2);
      chk("t3_write_count", 32'(log_addr.size()), 32'd2);
      chk("t3_pending", 32'(exp_addr_q.size()), 32'd0);
      log_addr.delete(); log_data.delete();

      // 4a: zero count finishes on the next cycle
      do_start(16'd0);
      chk("t4_zero_done", {31'd0, done}, 32'd1);
      chk("t4_zero_cycle", 32'(cyc - start_cyc), 32'd1);
      chk("t4_zero_ww", {16'd0, words_written}, 32'd0);

      // 4b: count above capacity
      do_start(16'd257);
      ready_seen = 1'b0;
      byte_valid = 1'b1;
      byte_in = 8'hAA;
      for (int k = 0; k < 8; k++) begin
         chk("t4_err_error", {31'd0, error}, 32'd1);
         chk("t4_err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
         if (byte_ready) ready_seen = 1'b1;
         @(negedge clk);
      end
      byte_valid = 1'b0;
      chk("t4_err_no_ready", {31'd0, ready_seen}, 32'd0);
      chk("t4_err_no_write", 32'(log_addr.size()), 32'd0);

      // 5: reset after two accepted bytes
      do_start(16'd2);
      send_stream(head, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("t5_reset");
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_no_write", 32'(log_addr.size()), 32'd0);
      chk("t5_idle_busy", {31'd0, busy}, 32'd0);
      expect_words(prog2);
      do_start(16'd2);
      send_stream(prog2, 1'b0);
      wait_done();
      chk("t5_reload_ww", {16'd0, words_written}, 32'd2);
      chk("t5_reload_writes", 32'(log_addr.size()), 32'd2);
      log_addr.delete(); log_data.delete();

      // 6: start ignored during RECV, then restart from DONE
      expect_words(prog2);
      do_start(16'd2);
      send_stream(head, 1'b0);
      start = 1'b1;
      word_count = 16'd1;
      @(negedge clk);
      start = 1'b0;
      chk("t6_still_busy", {31'd0, busy}, 32'd1);
      send_stream(tail, 1'b0);
      wait_done();
      chk("t6_ignored_ww", {16'd0, words_written}, 32'd2);
      expect_words(prog1);
      do_start(16'd1);
      chk("t6_restart_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t6_restart_done", {31'd0, done}, 32'd0);
      send_stream(prog1, 1'b0);
      wait_done();
      chk("t6_final_ww", {16'd0, words_written}, 32'd1);
      chk("t6_write_count", 32'(log_addr.size()), 32'd3);
      if (log_addr.size() == 3) begin
         chk("t6_lit_addr", log_addr[2], 32'h0);
         chk("t6_lit_data", log_data[2], 32'h0000006F);
      end
      chk("t6_pending", 32'(exp_addr_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a single-cycle write port at sequential word addresses.
- Holds the CPU core (PC, register file) in hold until the programmed word count has been loaded.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr (byte address).
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0, byte address of the first word written; must be 4-aligned.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- word_count  input  16  number of words to load; sampled on an accepted start.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_WIDTH  byte address of the current word.
- mem_wdata  output  32  assembled word.
- cpu_hold  output  1  1 = CPU must not fetch or advance.
- busy  output  1  load in progress (RECV or WRITE).
- done  output  1  load completed.
- error  output  1  word_count exceeds DEPTH_WORDS.
- words_written  output  16  words committed in the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, words_written=0, cpu_hold=1.
  - The byte lane index and any partial word are cleared.
- FSM states are IDLE, RECV, WRITE, DONE, ERR. All outputs are registered or decoded from state only (Moore).
- Start handling, from IDLE, DONE or ERR:
  - word_count is latched.
  - words_written=0, mem_addr=BASE_ADDR, lane index=0.
  - If word_count==0: go to DONE.
  - Else if word_count>DEPTH_WORDS: go to ERR.
  - Else: go to RECV.
  - start is ignored in RECV and WRITE.
- RECV:
  - byte_ready=1, busy=1.
  - A byte transfers when byte_valid && byte_ready.
  - Lane k (0..3) is written to bits [8k+7:8k]; the first byte received is the LSB.
  - On the transfer into lane 3, go to WRITE.
  - No transfer occurs when byte_valid=0; gaps of any length are allowed.
- WRITE (exactly one cycle):
  - mem_we=1, byte_ready=0, mem_wdata=assembled word, mem_addr=current address.
  - On exit: words_written increments, mem_addr increments by 4, and the lane index returns to 0.
  - If the new words_written equals the latched count, go to DONE; else go to RECV.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 write).
- DONE:
  - done=1, cpu_hold=0, busy=0, byte_ready=0.
  - mem_addr holds the last written address + 4.
  - A start in DONE clears done and reasserts cpu_hold in the next cycle.
- ERR:
  - error=1, cpu_hold=1, byte_ready=0, and no writes occur.
  - ERR is left only by start or reset.
- cpu_hold=1 in every state except DONE.
- Reset mid-operation: the partial word is discarded and no further mem_we is issued. Already-written memory contents are left as they are.
- The byte stream is never back-pressured mid-word except during WRITE. A byte offered during WRITE waits until the next RECV cycle.

Test Plan:
1. Reset behaviour: hold reset=0 for 3 cycles, then release. Required: cpu_hold=1, mem_addr=0, and all other outputs 0; byte_ready stays 0 until start.
2. Two-word load with word_count=2 and bytes 13 05 00 00 B3 02 A5 00, byte_valid held high.
   - mem_we pulses twice: addr 0x0 with data 0x00000513, then addr 0x4 with data 0x00A502B3.
   - done=1 and cpu_hold=0 from cycle 11 after the start; words_written=2.
3. Gapped stream: same bytes as test 2 with byte_valid low on every other cycle. Required: identical writes, and no byte is lost or duplicated.
4. Boundary counts:
   - word_count=0 gives done=1 on the cycle after start, with no mem_we.
   - word_count=257 (DEPTH_WORDS=256) gives error=1 and cpu_hold=1, with byte_ready never asserted.
5. Reset mid-word: assert reset after 2 bytes are accepted. Required: no mem_we, state IDLE. A fresh load of test 2 then writes correctly.
6. Restart: a start during RECV is ignored. A start in DONE with word_count=1 and bytes 6F 00 00 00 reasserts cpu_hold, writes 0x0000006F at 0x0, then reaches DONE again.
